sinc_decimator: RTL and testbench
=================================

Name: sinc_decimator

Overview:
- Parametrised successor to the fixed sinc2/512 digital_filter.
- Decimates the 1-bit modulator stream from the iADC front end into OUT_W-bit words. Filter order, oversampling ratio and output scaling are set by parameters.
- Two modes: one-shot incremental conversion, as digital_filter does, and continuous CIC decimation, which digital_filter lacks.
- Adds output saturation, busy/overrun status, and the same cs_n/sclk serial readout as digital_filter, with sclk and cs_n sampled in the clk domain.

Parameters:
ORDER, 2, number of cascaded integrators (and combs in continuous mode); legal range 1..3
OSR_LOG2, 9, decimation ratio R = 2^OSR_LOG2
OUT_W, 12, output word width
SHIFT, 6, right shift applied to the filter result before saturation

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  sample enable; data_in is consumed only on cycles with en=1
start  in  1  one-cycle pulse; clears the filter state and begins operation in the mode present on the mode input
mode  in  1  0 = one-shot incremental, 1 = continuous CIC; sampled only when start=1
data_in  in  1  modulator bit
data_out  out  OUT_W  last filter result, held until the next update
new_data  out  1  one-cycle pulse; data_out is updated in the same cycle
busy  out  1  high while a conversion or continuous run is active
sat  out  1  high while data_out holds a saturated value
sclk  in  1  serial clock, asynchronous to clk
cs_n  in  1  serial chip select, active-low, asynchronous to clk
serial_data_out  out  1  serial readout data, MSB first
overrun  out  1  sticky flag: a new word arrived during a readout

Behaviour:
- Reset: every register is cleared. data_out=0, new_data=0, busy=0, sat=0, serial_data_out=0, overrun=0.
- Integrator width ACC_W = ORDER*OSR_LOG2+1. Integrators wrap modulo 2^ACC_W; this is exact for the CIC.
- Integrator update per enabled sample: y1 += x, then yk += y(k-1) using the updated y(k-1) in the same cycle.
- start (accepted while idle or busy): clear all integrators, combs and the sample counter; latch mode; set busy=1. The first sample is taken on the next cycle with en=1.
- One-shot mode:
  - After exactly R enabled samples, the result is y_ORDER with no comb.
  - Next cycle: data_out = min(result>>SHIFT, 2^OUT_W-1); new_data=1; busy=0.
  - Further samples are ignored until the next start.
- Continuous mode:
  - Integrators run on every enabled sample.
  - Every R enabled samples, the decimated y_ORDER value passes through ORDER comb stages (differential delay 1).
  - The first ORDER-1 decimated outputs after start are warm-up values and are not published.
  - After warm-up, new_data pulses once every R enabled samples.
  - busy stays 1 until rst or the next start.
- Common to both modes:
  - en=0 stalls the counter and integrators; no state is lost.
  - Latency: new_data is asserted the cycle after the cycle that captured the R-th sample.
  - sat is updated together with data_out: 1 if result>>SHIFT > 2^OUT_W-1, else 0.
  - start in the same cycle as a completing sample: start wins and no word is published.
- Serial readout:
  - sclk and cs_n each pass through a 2-flop synchroniser and then an edge detector.
  - Detected cs_n fall: load shadow register from data_out; drive serial_data_out = shadow[OUT_W-1]; clear overrun.
  - Detected sclk fall while cs_n is low: shift shadow left and drive the next bit.
  - After OUT_W bits, serial_data_out = 0.
  - cs_n high: serial_data_out = 0.
  - Hosts sample serial_data_out on the rising edge of sclk. The sclk high and low phases each last at least 4 clk periods.
  - new_data while cs_n is low: data_out updates, the shadow register is untouched, and overrun is set.
- rst in the middle of a conversion or readout aborts it immediately and applies the reset values.

Test Plan:
- Defaults, mode=0, all-ones input for 512 enabled samples -> one new_data pulse, data_out=2052 (131328>>6), sat=0, busy falls in the pulse cycle.
- Defaults, mode=0, alternating input 1,0,1,... starting with 1 -> data_out=1028 (65792>>6); all-zeros input -> data_out=0.
- Defaults, mode=1, all-ones input -> first decimated word suppressed; new_data every 512 samples afterwards; data_out=4095 with sat=1 (4096 saturates). Same with alternating input -> data_out=2048, sat=0.
- en toggled 1,0 every cycle during a one-shot conversion -> same data_out as with en held high; new_data after 1024 clk cycles.
- Read a word with data_out=0xA5C: cs_n low, then 12 sclk pulses of 5 clk high and 5 clk low -> serial bits 101001011100, serial_data_out=0 afterwards. A new_data during the readout -> the serial bits are unchanged and overrun=1, cleared at the next cs_n fall.
- rst asserted at sample 300, then start -> no new_data from the aborted conversion; the next conversion is correct. start at sample 511 -> no word published; the next word is published 512 samples later.

Source files
------------

// File: rtl/sinc_decimator.sv
// Sinc^ORDER decimator for a 1-bit modulator stream: one-shot incremental or continuous CIC,
// with saturating output scaling and a cs_n/sclk serial readout synchronised into clk.
module sinc_decimator #(
    parameter int unsigned ORDER    = 2,
    parameter int unsigned OSR_LOG2 = 9,
    parameter int unsigned OUT_W    = 12,
    parameter int unsigned SHIFT    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    input  logic             data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             new_data,
    output logic             busy,
    output logic             sat,
    input  logic             sclk,
    input  logic             cs_n,
    output logic             serial_data_out,
    output logic             overrun
);

    localparam int unsigned ACC_W  = ORDER * OSR_LOG2 + 1;
    localparam int unsigned CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned BCNT_W = $clog2(OUT_W + 1);
    localparam logic [CMP_W-1:0] MaxOut = CMP_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {StIdle, StOneShot, StCont} state_e;

    state_e              state_q;
    logic [ACC_W-1:0]    integ_q  [ORDER];
    logic [ACC_W-1:0]    integ_nx [ORDER];
    logic [ACC_W-1:0]    comb_q   [ORDER];
    logic [ACC_W-1:0]    comb_nx  [ORDER];
    logic [OSR_LOG2-1:0] cnt_q;
    logic [1:0]          warm_q;
    logic [OUT_W-1:0]    data_out_q;
    logic                new_data_q, sat_q;

    logic [ACC_W-1:0] comb_out, result;
    logic [CMP_W-1:0] scaled;
    logic [OUT_W-1:0] word;
    logic             word_sat, step, last, publish;

    // Integrator chain uses the freshly updated lower stage; combs see the new y_ORDER.
    always_comb begin
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] val;
        acc = ACC_W'(data_in);
        for (int k = 0; k < int'(ORDER); k++) begin
            acc         = integ_q[k] + acc;
            integ_nx[k] = acc;
        end
        val = acc;
        for (int k = 0; k < int'(ORDER); k++) begin
            comb_nx[k] = val;
            val        = val - comb_q[k];
        end
        comb_out = val;
    end

    always_comb begin
        step     = en && (state_q != StIdle);
        last     = (cnt_q == '1);
        result   = (state_q == StCont) ? comb_out : integ_nx[ORDER-1];
        scaled   = CMP_W'(result) >> SHIFT;
        word_sat = (scaled > MaxOut);
        word     = word_sat ? '1 : scaled[OUT_W-1:0];
        publish  = step && last && !start &&
                   ((state_q == StOneShot) || (warm_q == 2'(ORDER - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            warm_q     <= '0;
            data_out_q <= '0;
            new_data_q <= 1'b0;
            sat_q      <= 1'b0;
            for (int k = 0; k < int'(ORDER); k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
            end
        end else begin
            new_data_q <= publish;
            if (publish) begin
                data_out_q <= word;
                sat_q      <= word_sat;
            end
            if (start) begin
                state_q <= mode ? StCont : StOneShot;
                cnt_q   <= '0;
                warm_q  <= '0;
                for (int k = 0; k < int'(ORDER); k++) begin
                    integ_q[k] <= '0;
                    comb_q[k]  <= '0;
                end
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
                for (int k = 0; k < int'(ORDER); k++) integ_q[k] <= integ_nx[k];
                if (last) begin
                    if (state_q == StOneShot) begin
                        state_q <= StIdle;
                    end else begin
                        for (int k = 0; k < int'(ORDER); k++) comb_q[k] <= comb_nx[k];
                        if (warm_q != 2'(ORDER - 1)) warm_q <= warm_q + 2'd1;
                    end
                end
            end
        end
    end

    logic [1:0]        sclk_sync_q, cs_sync_q;
    logic              sclk_prev_q, cs_prev_q;
    logic [OUT_W-1:0]  shadow_q;
    logic [BCNT_W-1:0] bits_q;
    logic              sdo_q, overrun_q;
    logic              sclk_s, cs_s, sclk_fall, cs_fall;
    logic [OUT_W-1:0]  shadow_shl;

    always_comb begin
        sclk_s     = sclk_sync_q[1];
        cs_s       = cs_sync_q[1];
        sclk_fall  = sclk_prev_q && !sclk_s;
        cs_fall    = cs_prev_q && !cs_s;
        shadow_shl = shadow_q << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            shadow_q    <= '0;
            bits_q      <= '0;
            sdo_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            if (cs_s) begin
                sdo_q <= 1'b0;
            end else if (cs_fall) begin
                shadow_q <= data_out_q;
                sdo_q    <= data_out_q[OUT_W-1];
                bits_q   <= BCNT_W'(1);
            end else if (sclk_fall) begin
                if (bits_q < BCNT_W'(OUT_W)) begin
                    shadow_q <= shadow_shl;
                    sdo_q    <= shadow_shl[OUT_W-1];
                    bits_q   <= bits_q + 1'b1;
                end else begin
                    sdo_q <= 1'b0;
                end
            end
            // A word landing mid-readout must be flagged even if cs_n falls the same cycle.
            if (publish && !cs_s) overrun_q <= 1'b1;
            else if (cs_fall)     overrun_q <= 1'b0;
        end
    end

    assign data_out        = data_out_q;
    assign new_data        = new_data_q;
    assign sat             = sat_q;
    assign busy            = (state_q != StIdle);
    assign serial_data_out = sdo_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sinc_decimator.sv
// Self-checking bench for sinc_decimator: random stimulus against a convolution-based model
// (boxcar weights for one-shot, triangular CIC impulse response for continuous mode).
module tb_sinc_decimator;

    localparam int unsigned ORDER    = 2;
    localparam int unsigned OSR_LOG2 = 9;
    localparam int unsigned OUT_W    = 12;
    localparam int unsigned SHIFT    = 6;
    localparam int          R        = 1 << OSR_LOG2;

    logic             clk = 1'b0;
    logic             rst, en, start, mode, data_in, sclk, cs_n;
    logic [OUT_W-1:0] data_out;
    logic             new_data, busy, sat, serial_data_out, overrun;

    int errors = 0;
    int checks = 0;
    bit samp[$];

    always #5 clk = ~clk;

    sinc_decimator #(
        .ORDER   (ORDER),
        .OSR_LOG2(OSR_LOG2),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .start          (start),
        .mode           (mode),
        .data_in        (data_in),
        .data_out       (data_out),
        .new_data       (new_data),
        .busy           (busy),
        .sat            (sat),
        .sclk           (sclk),
        .cs_n           (cs_n),
        .serial_data_out(serial_data_out),
        .overrun        (overrun)
    );

    task automatic step(input logic e, input logic b);
        en      = e;
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        en    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'b0;
    endtask

    function automatic logic pat_bit(input int pat, input int k);
        case (pat)
            0:       return 1'b1;
            1:       return (k % 2 == 0);
            2:       return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic en_bit(input int em, input int cyc);
        case (em)
            0:       return 1'b1;
            1:       return (cyc % 2 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // One-shot: y_2 after R samples weights sample i by (R - i).
    function automatic longint oneshot_ref();
        longint s = 0;
        for (int i = 0; i < R; i++) s += longint'(R - i) * longint'(samp[i]);
        return s;
    endfunction

    // Continuous: order-2 CIC output is the input convolved with a triangle of length 2R-1.
    function automatic longint cic_ref(input int n);
        longint s = 0;
        for (int j = 0; j <= 2 * R - 2; j++) begin
            int idx;
            int h;
            idx = n - 1 - j;
            h   = (j < R) ? j + 1 : 2 * R - 1 - j;
            if (idx >= 0) s += longint'(h) * longint'(samp[idx]);
        end
        return s;
    endfunction

    function automatic logic [OUT_W:0] scale(input longint v);
        longint s;
        s = v >> SHIFT;
        if (s > longint'((1 << OUT_W) - 1)) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, s[OUT_W-1:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 1'b0; data_in = 1'b0;
        sclk = 1'b0; cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
        checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL reset_new_data got=%b exp=0", new_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", sat); end
        checks++; if (serial_data_out !== 1'b0) begin errors++; $display("FAIL reset_sdo got=%b exp=0", serial_data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_oneshot(input string name, input int pat, input int em);
        logic [OUT_W:0]   exp;
        logic [OUT_W-1:0] held;
        int k = 0, cyc = 0, early = 0, late = 0;
        logic e, b;
        do_start(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_start got=%b exp=1", name, busy); end
        samp.delete();
        while (k < R && cyc < 4 * R) begin
            e = en_bit(em, cyc);
            b = pat_bit(pat, k);
            step(e, b);
            cyc++;
            if (e) begin samp.push_back(b); k++; end
            if (k < R && new_data) early++;
        end
        exp = scale(oneshot_ref());
        checks++; if (new_data !== 1'b1 || early != 0)
            begin errors++; $display("FAIL %s_pulse got=%b early=%0d exp=1", name, new_data, early); end
        checks++; if (data_out !== exp[OUT_W-1:0])
            begin errors++; $display("FAIL %s_data got=%0d exp=%0d", name, data_out, exp[OUT_W-1:0]); end
        checks++; if (sat !== exp[OUT_W]) begin errors++; $display("FAIL %s_sat got=%b exp=%b", name, sat, exp[OUT_W]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", name, busy); end
        // Toggled en: 512th enabled sample lands on step 2R-1, i.e. 2R cycles counting start.
        if (em == 1) begin
            checks++; if (cyc != 2 * R - 1) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, 2 * R - 1); end
        end
        held = data_out;
        repeat (40) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            if (new_data) late++;
        end
        checks++; if (late != 0 || data_out !== held)
            begin errors++; $display("FAIL %s_ignored got=%0d/%0d exp=0/%0d", name, late, data_out, held); end
    endtask

    task automatic test_continuous(input string name, input int pat, input int em, input int nwords);
        logic [OUT_W:0] exp;
        int k = 0, cyc = 0;
        logic e, b;
        do_start(1'b1);
        samp.delete();
        while (k < nwords * R && cyc < 4 * nwords * R) begin
            e = en_bit(em, cyc);
            b = pat_bit(pat, k);
            step(e, b);
            cyc++;
            if (e) begin
                samp.push_back(b);
                k++;
            end
            if (e && (k % R == 0)) begin
                if (k / R < int'(ORDER)) begin
                    checks++; if (new_data !== 1'b0)
                        begin errors++; $display("FAIL %s_warmup got=%b exp=0", name, new_data); end
                end else begin
                    exp = scale(cic_ref(k));
                    checks++; if (new_data !== 1'b1 || data_out !== exp[OUT_W-1:0] || sat !== exp[OUT_W])
                        begin errors++; $display("FAIL %s_word%0d got=%b/%0d/%b exp=1/%0d/%b", name, k / R,
                                                 new_data, data_out, sat, exp[OUT_W-1:0], exp[OUT_W]); end
                end
            end else if (new_data) begin
                checks++; errors++;
                $display("FAIL %s_spurious got=1 exp=0 at sample %0d", name, k);
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
    endtask

    task automatic readout(input bit inject, output logic [OUT_W-1:0] got, output int pulses);
        pulses = 0;
        got    = '0;
        cs_n   = 1'b0;
        repeat (6) step(1'b0, 1'b0);
        for (int i = 0; i < int'(OUT_W); i++) begin
            got[OUT_W-1-i] = serial_data_out;
            sclk = 1'b1;
            repeat (5) step(1'b0, 1'b0);
            sclk = 1'b0;
            repeat (5) step(1'b0, 1'b0);
            if (inject && i == 3) begin
                for (int s = 0; s < R; s++) begin
                    logic b;
                    b = 1'($urandom_range(0, 1));
                    samp.push_back(b);
                    step(1'b1, b);
                    if (new_data) pulses++;
                end
            end
        end
    endtask

    task automatic test_serial();
        bit               sel [2 * R];
        longint           rem;
        logic [OUT_W-1:0] got;
        logic [OUT_W:0]   exp;
        int               pulses;
        // Pick input bits whose second CIC word is exactly 0xA5C << SHIFT (greedy on weights).
        rem = longint'(12'hA5C) << SHIFT;
        for (int i = 0; i < 2 * R; i++) sel[i] = 1'b0;
        for (int w = R; w >= 1; w--) begin
            int j1, j2;
            j1 = w - 1;
            j2 = 2 * R - 1 - w;
            if (rem >= w) begin sel[2 * R - 1 - j1] = 1'b1; rem -= w; end
            if (j2 != j1 && rem >= w) begin sel[2 * R - 1 - j2] = 1'b1; rem -= w; end
        end
        do_start(1'b1);
        samp.delete();
        for (int i = 0; i < 2 * R; i++) begin
            samp.push_back(sel[i]);
            step(1'b1, sel[i]);
        end
        exp = scale(cic_ref(2 * R));
        checks++; if (data_out !== 12'hA5C || data_out !== exp[OUT_W-1:0])
            begin errors++; $display("FAIL serial_setup got=%h exp=a5c", data_out); end

        readout(1'b0, got, pulses);
        checks++; if (got !== 12'hA5C) begin errors++; $display("FAIL serial_bits got=%b exp=101001011100", got); end
        checks++; if (serial_data_out !== 1'b0) begin errors++; $display("FAIL serial_tail got=%b exp=0", serial_data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL serial_no_overrun got=%b exp=0", overrun); end
        cs_n = 1'b1;
        repeat (6) step(1'b0, 1'b0);
        checks++; if (serial_data_out !== 1'b0) begin errors++; $display("FAIL serial_cs_high got=%b exp=0", serial_data_out); end

        readout(1'b1, got, pulses);
        exp = scale(cic_ref(3 * R));
        checks++; if (got !== 12'hA5C) begin errors++; $display("FAIL overrun_bits got=%b exp=101001011100", got); end
        checks++; if (pulses != 1 || data_out !== exp[OUT_W-1:0])
            begin errors++; $display("FAIL overrun_word got=%0d/%0d exp=1/%0d", pulses, data_out, exp[OUT_W-1:0]); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        cs_n = 1'b1;
        repeat (6) step(1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
        cs_n = 1'b0;
        repeat (6) step(1'b0, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
        cs_n = 1'b1;
        repeat (6) step(1'b0, 1'b0);
    endtask

    task automatic test_rst_abort();
        int pulses = 0;
        do_start(1'b0);
        repeat (300) step(1'b1, 1'($urandom_range(0, 1)));
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || data_out !== '0 || sat !== 1'b0)
            begin errors++; $display("FAIL abort_reset got=%b/%0d/%b exp=0/0/0", busy, data_out, sat); end
        repeat (2 * R) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            if (new_data) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_word got=%0d exp=0", pulses); end
        test_oneshot("after_abort", 3, 2);
    endtask

    task automatic test_start_collision();
        logic [OUT_W:0] exp;
        int early = 0;
        do_start(1'b0);
        repeat (R - 1) step(1'b1, 1'($urandom_range(0, 1)));
        start = 1'b1;
        step(1'b1, 1'b1);
        start = 1'b0;
        checks++; if (new_data !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL collide_start_wins got=%b/%b exp=0/1", new_data, busy); end
        samp.delete();
        for (int i = 0; i < R; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            samp.push_back(b);
            step(1'b1, b);
            if (i < R - 1 && new_data) early++;
        end
        exp = scale(oneshot_ref());
        checks++; if (new_data !== 1'b1 || early != 0 || data_out !== exp[OUT_W-1:0])
            begin errors++; $display("FAIL collide_next_word got=%b/%0d/%0d exp=1/0/%0d",
                                     new_data, early, data_out, exp[OUT_W-1:0]); end
    endtask

    initial begin
        test_reset();
        test_oneshot("os_ones", 0, 0);
        test_oneshot("os_alt", 1, 0);
        test_oneshot("os_zeros", 2, 0);
        test_oneshot("os_toggle_en", 0, 1);
        test_oneshot("os_random", 3, 2);
        test_continuous("cic_ones", 0, 0, 3);
        test_continuous("cic_alt", 1, 0, 3);
        test_continuous("cic_random", 3, 2, 4);
        test_serial();
        test_rst_abort();
        test_start_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
